// File: rtl/float_to_int_if.sv
// Stream handshake bundle for float_to_int: binary32 operand in, signed integer result out.
interface float_to_int_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport slave (
    input  input_a,
    input  input_a_stb,
    output input_a_ack,
    output output_z,
    output output_z_stb,
    input  output_z_ack
  );

  modport master (
    output input_a,
    output input_a_stb,
    input  input_a_ack,
    input  output_z,
    input  output_z_stb,
    output output_z_ack
  );
endinterface

// File: rtl/float_to_int.sv
// Iterative binary32 -> signed 32-bit integer converter on stb/ack streams.
// Truncates toward zero unless FLOAT_TO_INT_ROUND_NEAREST_EN selects round-to-nearest-even.
module float_to_int #(
  parameter int unsigned INT_W = 32
) (
  input logic            clk,
  input logic            rst,
  float_to_int_if.slave  bus
);

  localparam logic [2:0] StGetA    = 3'd0;
  localparam logic [2:0] StUnpack  = 3'd1;
  localparam logic [2:0] StSpecial = 3'd2;
  localparam logic [2:0] StShift   = 3'd3;
  localparam logic [2:0] StPack    = 3'd4;
  localparam logic [2:0] StPutZ    = 3'd5;

  localparam logic [INT_W-1:0] IntMin = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] IntMax = {1'b0, {(INT_W-1){1'b1}}};

  logic [2:0]       state;
  logic [31:0]      a;
  logic             s;
  logic signed [9:0] e;
  logic [INT_W-1:0] m;
  logic [INT_W-1:0] z;
  logic [INT_W-1:0] mag;

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
  logic guard_bit;
  logic round_bit;
  logic sticky_bit;
  logic round_up;

  always_comb begin
    round_up = guard_bit & (round_bit | sticky_bit | m[0]);
    mag      = m + {{(INT_W-1){1'b0}}, round_up};
  end
`else
  always_comb begin
    mag = m;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= StGetA;
      a                <= '0;
      s                <= 1'b0;
      e                <= '0;
      m                <= '0;
      z                <= '0;
      bus.input_a_ack  <= 1'b0;
      bus.output_z_stb <= 1'b0;
      bus.output_z     <= '0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
      guard_bit        <= 1'b0;
      round_bit        <= 1'b0;
      sticky_bit       <= 1'b0;
`endif
    end else begin
      unique case (state)
        StGetA: begin
          bus.input_a_ack <= 1'b1;
          if (bus.input_a_stb && bus.input_a_ack) begin
            a               <= bus.input_a;
            bus.input_a_ack <= 1'b0;
            state           <= StUnpack;
          end
        end

        StUnpack: begin
          s <= a[31];
          e <= $signed({2'b00, a[30:23]}) - 10'sd127;
          m <= {1'b1, a[22:0], 8'd0};
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
          guard_bit  <= 1'b0;
          round_bit  <= 1'b0;
          sticky_bit <= 1'b0;
`endif
          state <= StSpecial;
        end

        StSpecial: begin
          if (a[30:23] == 8'hff && a[22:0] != 23'd0) begin
            z     <= IntMin;
            state <= StPutZ;
          end else if (a[30:23] == 8'hff) begin
            z     <= s ? IntMin : IntMax;
            state <= StPutZ;
          end else if (a[30:23] == 8'h00) begin
            z     <= '0;
            state <= StPutZ;
          end else if (e < 10'sd0) begin
            // |x| < 1: magnitude is zero, only the rounding bits can lift it to 1.
            m <= '0;
            e <= 10'sd31;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            guard_bit  <= (e == -10'sd1);
            round_bit  <= 1'b0;
            sticky_bit <= (e == -10'sd1) ? (a[22:0] != 23'd0) : 1'b1;
`endif
            state <= StShift;
          end else if (e > 10'sd30) begin
            z     <= s ? IntMin : IntMax;
            state <= StPutZ;
          end else begin
            state <= StShift;
          end
        end

        StShift: begin
          if (e < 10'sd31) begin
            m <= m >> 1;
            e <= e + 10'sd1;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            guard_bit  <= m[0];
            round_bit  <= guard_bit;
            sticky_bit <= sticky_bit | round_bit;
`endif
          end
          if (e >= 10'sd30) begin
            state <= StPack;
          end
        end

        StPack: begin
          z     <= s ? (~mag + 1'b1) : mag;
          state <= StPutZ;
        end

        StPutZ: begin
          if (bus.output_z_stb && bus.output_z_ack) begin
            bus.output_z_stb <= 1'b0;
            state            <= StGetA;
          end else begin
            bus.output_z_stb <= 1'b1;
            bus.output_z     <= z;
          end
        end

        default: state <= StGetA;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int: values, handshake latency, backpressure and mid-operation reset.
module tb_float_to_int;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  float_to_int_if bus ();

  float_to_int #(.INT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
  localparam logic [31:0] Exp275  = 32'h0000_0003;
  localparam logic [31:0] Exp075  = 32'h0000_0001;
  localparam logic [31:0] ExpN075 = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] Exp275  = 32'h0000_0002;
  localparam logic [31:0] Exp075  = 32'h0000_0000;
  localparam logic [31:0] ExpN075 = 32'h0000_0000;
`endif

  typedef struct {
    logic [31:0] v;
    logic [31:0] z;
    int          lat;
  } vec_t;

  // Latency counted in clock edges after the input handshake edge.
  vec_t vecs [13] = '{
    '{32'h3F80_0000, 32'h0000_0001, 35},  // 1.0, e=0
    '{32'hC020_0000, 32'hFFFF_FFFE, 34},  // -2.5, e=1
    '{32'h4030_0000, Exp275,        34},  // 2.75
    '{32'h42F6_0000, 32'h0000_007B, 29},  // 123.0, e=6
    '{32'h4F32_D05E, 32'h7FFF_FFFF, 3},   // ~3e9 saturates
    '{32'hCF00_0000, 32'h8000_0000, 3},   // -2^31
    '{32'hFF80_0000, 32'h8000_0000, 3},   // -inf
    '{32'h7FC0_0000, 32'h8000_0000, 3},   // NaN
    '{32'h0000_0001, 32'h0000_0000, 3},   // denormal
    '{32'h3F00_0000, 32'h0000_0000, 5},   // 0.5 tie to even
    '{32'h3F40_0000, Exp075,        5},   // 0.75
    '{32'hBF40_0000, ExpN075,       5},   // -0.75
    '{32'h3E80_0000, 32'h0000_0000, 5}    // 0.25
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present an operand and wait until the result strobe rises; leaves stb high.
  task automatic send(input string tag, input logic [31:0] v, input logic [31:0] exp_z,
                      input int exp_lat);
    int n;
    bus.input_a     = v;
    bus.input_a_stb = 1'b1;
    n = 0;
    while (!bus.input_a_ack && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ack"}, {31'b0, bus.input_a_ack}, 32'd1);
    @(posedge clk); #1;
    bus.input_a_stb = 1'b0;
    n = 0;
    while (!bus.output_z_stb && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_z"}, bus.output_z, exp_z);
  endtask

  task automatic drain(input string tag);
    bus.output_z_ack = 1'b1;
    @(posedge clk); #1;
    bus.output_z_ack = 1'b0;
    check({tag, "_stb_drop"}, {31'b0, bus.output_z_stb}, 32'd0);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    bus.input_a      = '0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stb", {31'b0, bus.output_z_stb}, 32'd0);
    check("rst_z", bus.output_z, 32'd0);
    check("rst_ack", {31'b0, bus.input_a_ack}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ack", {31'b0, bus.input_a_ack}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      send($sformatf("v%0d", i), vecs[i].v, vecs[i].z, vecs[i].lat);
      drain($sformatf("v%0d", i));
    end

    // Backpressure: result must hold while the consumer stalls.
    send("bp", 32'h3F80_0000, 32'h0000_0001, 35);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_stb%0d", i), {31'b0, bus.output_z_stb}, 32'd1);
      check($sformatf("bp_z%0d", i), bus.output_z, 32'h0000_0001);
      check($sformatf("bp_ack%0d", i), {31'b0, bus.input_a_ack}, 32'd0);
    end
    drain("bp");
    check("bp_ack_late", {31'b0, bus.input_a_ack}, 32'd0);
    @(posedge clk); #1;
    check("bp_ack_next", {31'b0, bus.input_a_ack}, 32'd1);

    // Reset while 0x4EFFFFFF (e=30) sits in the shift state.
    bus.input_a     = 32'h4EFF_FFFF;
    bus.input_a_stb = 1'b1;
    @(posedge clk); #1;
    bus.input_a_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_stb", {31'b0, bus.output_z_stb}, 32'd0);
    check("mrst_z", bus.output_z, 32'd0);
    check("mrst_ack", {31'b0, bus.input_a_ack}, 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.output_z_stb) break;
    end
    check("mrst_no_out", {31'b0, bus.output_z_stb}, 32'd0);
    send("post_rst", 32'h4000_0000, 32'h0000_0002, 34);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
